// File: rtl/alu_exec_sequencer_pkg.sv
// rtl/alu_exec_sequencer_pkg.sv - shared state, instruction-class and ALU-op definitions
package alu_exec_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_RN = 3'd1,
        ST_RD_RM = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_e;

    // Instruction classes (instr[15:14]); the other two codes are undefined.
    localparam logic [1:0] CLS_A = 2'b00;
    localparam logic [1:0] CLS_R = 2'b01;

    // A-type ALU opcodes (instr[13:9]); every other value is undefined.
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_EQUAL = 5'd1;
    localparam logic [4:0] OP_OR    = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_MINUS = 5'd4;

    // R-type conditions accepted for execution.
    localparam logic [1:0] RCOND_00 = 2'b00;
    localparam logic [1:0] RCOND_11 = 2'b11;

    function automatic logic [1:0] f_cls(input logic [15:0] i);
        return i[15:14];
    endfunction

    function automatic logic [4:0] f_op(input logic [15:0] i);
        return i[13:9];
    endfunction

    function automatic logic [2:0] f_rd_a(input logic [15:0] i);
        return i[8:6];
    endfunction

    function automatic logic [2:0] f_rn(input logic [15:0] i);
        return i[5:3];
    endfunction

    function automatic logic [2:0] f_rm(input logic [15:0] i);
        return i[2:0];
    endfunction

    function automatic logic [1:0] f_rcond(input logic [15:0] i);
        return i[13:12];
    endfunction

    function automatic logic [8:0] f_imm(input logic [15:0] i);
        return i[11:3];
    endfunction

    function automatic logic [2:0] f_rd_r(input logic [15:0] i);
        return i[2:0];
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_decode.sv
// rtl/alu_exec_sequencer_decode.sv - combinational instruction legality and register-field decode
//
// Ports:
//   instr_i        instruction word from decode
//   legal_o        instruction is a defined A-type op or an R-type with an accepted rcond
//   needs_reads_o  instruction reads rn/rm from the register file (A-type)
//   rd_o           destination register, taken from the field of the instruction's class
//   rn_o           first source register field (A-type layout)
module alu_exec_sequencer_decode
    import alu_exec_sequencer_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic        legal_o,
    output logic        needs_reads_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rn_o
);

    always_comb begin
        legal_o       = 1'b0;
        needs_reads_o = 1'b0;
        rd_o          = f_rd_a(instr_i);
        rn_o          = f_rn(instr_i);
        case (f_cls(instr_i))
            CLS_A: begin
                needs_reads_o = 1'b1;
                case (f_op(instr_i))
                    OP_ADD, OP_EQUAL, OP_OR, OP_AND, OP_MINUS: legal_o = 1'b1;
                    default:                                    legal_o = 1'b0;
                endcase
            end
            CLS_R: begin
                rd_o    = f_rd_r(instr_i);
                legal_o = (f_rcond(instr_i) == RCOND_00) || (f_rcond(instr_i) == RCOND_11);
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// rtl/alu_exec_sequencer.sv - multi-cycle execute controller between decode and regfile/ALU
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   flush                   synchronous abort of the in-flight instruction
//   instr_valid/instr_ready decode handshake; instr is the instruction word
//   rf_raddr/rf_rdata       single read port, data returns the cycle after the address
//   rf_we/rf_waddr/rf_wdata one-cycle writeback
//   alu_rn/alu_rm/alu_instr registered ALU inputs
//   alu_rd, alu_z/n/v       combinational ALU result and status
//   flag_z/n/v              architectural flags, changed only by a writeback
//   done/illegal            retire pulse, with illegal for undefined instructions
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DW-1:0]     rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [DW-1:0]     alu_rn,
    output logic [DW-1:0]     alu_rm,
    output logic [15:0]       alu_instr,
    input  logic [DW-1:0]     alu_rd,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_v,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              done,
    output logic              illegal
);

    state_e              state_q, state_d;
    logic [15:0]         alu_instr_q;
    logic [DW-1:0]       alu_rn_q, alu_rm_q;
    logic [REG_AW-1:0]   rd_q;
    logic                illegal_q;
    logic [DW-1:0]       res_q;
    logic                stg_z_q, stg_n_q, stg_v_q;
    logic                flag_z_q, flag_n_q, flag_v_q;

    logic                dec_legal, dec_needs_reads;
    logic [2:0]          dec_rd, dec_rn;
    logic                accept;

    alu_exec_sequencer_decode u_decode (
        .instr_i       (instr),
        .legal_o       (dec_legal),
        .needs_reads_o (dec_needs_reads),
        .rd_o          (dec_rd),
        .rn_o          (dec_rn)
    );

    // Gating with rst_n keeps ready low while reset is held, even though the FSM already sits in IDLE.
    assign instr_ready = rst_n && (state_q == ST_IDLE) && !flush;
    assign accept      = instr_ready && instr_valid;

    always_comb begin
        state_d  = state_q;
        rf_raddr = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // rn is addressed straight from decode so its data lands in RD_RN.
                    rf_raddr = REG_AW'(dec_rn);
                    if (!dec_legal) begin
                        state_d = ST_WB;
                    end else if (dec_needs_reads) begin
                        state_d = ST_RD_RN;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_RD_RN: begin
                rf_raddr = REG_AW'(f_rm(alu_instr_q));
                state_d  = ST_RD_RM;
            end
            ST_RD_RM: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done    = 1'b1;
                    illegal = illegal_q;
                    if (!illegal_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = rd_q;
                        rf_wdata = res_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_instr_q <= '0;
            alu_rn_q    <= '0;
            alu_rm_q    <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            res_q       <= '0;
            stg_z_q     <= 1'b0;
            stg_n_q     <= 1'b0;
            stg_v_q     <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            if (accept) begin
                alu_instr_q <= instr;
                rd_q        <= REG_AW'(dec_rd);
                illegal_q   <= !dec_legal;
                // R-type never reads operands, so they are presented as zero.
                alu_rn_q    <= '0;
                alu_rm_q    <= '0;
            end
            if (state_q == ST_RD_RN) begin
                alu_rn_q <= rf_rdata;
            end
            if (state_q == ST_RD_RM) begin
                alu_rm_q <= rf_rdata;
            end
            if (state_q == ST_EXEC) begin
                res_q   <= alu_rd;
                stg_z_q <= alu_z;
                stg_n_q <= alu_n;
                stg_v_q <= alu_v;
            end
            // rf_we already excludes flush and illegal, so flags move only with a real writeback.
            if (rf_we) begin
                flag_z_q <= stg_z_q;
                flag_n_q <= stg_n_q;
                flag_v_q <= stg_v_q;
            end
        end
    end

    assign alu_instr = alu_instr_q;
    assign alu_rn    = alu_rn_q;
    assign alu_rm    = alu_rm_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb/tb_alu_exec_sequencer.sv - self-checking bench for alu_exec_sequencer
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_rn, alu_rm, alu_instr, alu_rd;
    logic        alu_z, alu_n, alu_v;
    logic        flag_z, flag_n, flag_v;
    logic        done, illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_sequencer #(.REG_AW(3), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_rn(alu_rn), .alu_rm(alu_rm), .alu_instr(alu_instr),
        .alu_rd(alu_rd), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Register file model: one read port with one-cycle latency, write port shared with preload.
    logic [15:0] regs [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'h0;

    always @(posedge clk) begin
        rf_rdata <= regs[rf_raddr];
        if (rf_we) regs[rf_waddr] <= rf_wdata;
        else if (pre_we) regs[pre_addr] <= pre_data;
    end

    // ALU semantics: returns {v, n, z, result}.
    function automatic logic [18:0] alu_f(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        r = 16'h0;
        v = 1'b0;
        if (ins[15:14] == 2'b01) begin
            r = {{7{ins[11]}}, ins[11:3]};
        end else begin
            case (ins[13:9])
                5'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
                5'd1: r = (a == b) ? 16'd1 : 16'd0;
                5'd2: r = a | b;
                5'd3: r = a & b;
                5'd4: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
                default: r = 16'hDEAD;
            endcase
        end
        return {v, r[15], (r == 16'h0), r};
    endfunction

    assign {alu_v, alu_n, alu_z, alu_rd} = alu_f(alu_instr, alu_rn, alu_rm);

    // Reference state: expected register contents and flags {z,n,v}.
    logic [15:0] gold [8];
    logic [2:0]  gflags = 3'b000;
    logic [15:0] last_wdata = 16'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_a(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm);
        return {2'b00, op, rd, rn, rm};
    endfunction

    function automatic logic [15:0] mk_r(input logic [1:0] rc, input logic [8:0] imm, input logic [2:0] rd);
        return {2'b01, rc, imm, rd};
    endfunction

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        gold[a] = d;
    endtask

    // Issues one instruction from an IDLE cycle and follows it to retirement.
    task automatic run_instr(input logic [15:0] ins, input bit hold);
        logic [1:0]  cls;
        logic [4:0]  op;
        logic        legal;
        int          lat;
        logic [15:0] a, b;
        logic [18:0] r;
        logic [2:0]  wa;
        cls   = ins[15:14];
        op    = ins[13:9];
        legal = (cls == 2'd0 && op <= 5'd4) || (cls == 2'd1 && (ins[13:12] == 2'b00 || ins[13:12] == 2'b11));
        lat   = !legal ? 1 : ((cls == 2'd0) ? 4 : 2);
        a     = (cls == 2'd0) ? gold[ins[5:3]] : 16'h0;
        b     = (cls == 2'd0) ? gold[ins[2:0]] : 16'h0;
        r     = alu_f(ins, a, b);
        wa    = (cls == 2'd0) ? ins[8:6] : ins[2:0];
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        chk("ready", 64'(instr_ready), 64'(1'b1));
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (legal && c == lat - 1) chk("operands", 64'({alu_rn, alu_rm}), 64'({a, b}));
            if (c < lat) begin
                chk("early_done", 64'({done, rf_we}), 64'(0));
            end else begin
                chk("done", 64'({done, illegal}), 64'({1'b1, !legal}));
                chk("we", 64'(rf_we), 64'(legal));
                if (legal) begin
                    chk("waddr", 64'(rf_waddr), 64'(wa));
                    chk("wdata", 64'(rf_wdata), 64'(r[15:0]));
                    last_wdata = rf_wdata;
                end
            end
            @(posedge clk); #1;
        end
        if (legal) begin
            gold[wa] = r[15:0];
            gflags   = {r[16], r[17], r[18]};
        end
        chk("flags", 64'({flag_z, flag_n, flag_v}), 64'(gflags));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({instr_ready, rf_raddr, rf_we, rf_waddr, done, illegal, flag_z, flag_n, flag_v}), 64'(0));
        chk({tag, "_data"}, 64'({rf_wdata, alu_rn, alu_rm}), 64'(0));
        chk({tag, "_instr"}, 64'(alu_instr), 64'(0));
    endtask

    initial begin
        // Reset state.
        #1 rst_n = 1'b0;
        #11;
        chk_all_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        #1 chk("ready_after_reset", 64'(instr_ready), 64'(1'b1));
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0007);

        // ADD r3 = r1 + r2.
        run_instr(mk_a(5'd0, 3'd3, 3'd1, 3'd2), 1'b0);
        chk("add_value", 64'(last_wdata), 64'(16'h000C));
        chk("add_flags", 64'({flag_z, flag_n}), 64'(0));

        // MINUS r4 = r1 - r1.
        set_reg(3'd1, 16'h1234);
        run_instr(mk_a(5'd4, 3'd4, 3'd1, 3'd1), 1'b0);
        chk("minus_value", 64'(last_wdata), 64'(16'h0000));
        chk("minus_z", 64'(flag_z), 64'(1'b1));

        // R-type sign-extended immediate into r0.
        run_instr(mk_r(2'b00, 9'h1FF, 3'd0), 1'b0);
        chk("rtype_value", 64'(last_wdata), 64'(16'hFFFF));
        chk("rtype_n", 64'(flag_n), 64'(1'b1));

        // Illegal forms: undefined op, bad rcond, bad class.
        run_instr(mk_a(5'h1F, 3'd5, 3'd1, 3'd2), 1'b0);
        run_instr(mk_r(2'b01, 9'h0AA, 3'd2), 1'b0);
        run_instr({2'b10, 14'h1234}, 1'b0);
        chk("illegal_keeps_n", 64'(flag_n), 64'(1'b1));

        // Flush while in EXEC.
        instr = mk_a(5'd0, 3'd5, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_exec_outs", 64'({done, rf_we, instr_ready}), 64'(0));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_exec_idle", 64'({instr_ready, done, rf_we}), 64'(3'b100));
        @(posedge clk); #1;
        chk("flush_exec_no_wb", 64'(regs[5]), 64'(gold[5]));
        chk("flush_exec_flags", 64'({flag_z, flag_n, flag_v}), 64'(gflags));

        // Flush in the writeback cycle.
        instr = mk_a(5'd2, 3'd6, 3'd3, 3'd4);
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wb_outs", 64'({done, rf_we, illegal}), 64'(0));
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_wb_idle", 64'(instr_ready), 64'(1'b1));
        chk("flush_wb_no_wb", 64'(regs[6]), 64'(gold[6]));
        chk("flush_wb_flags", 64'({flag_z, flag_n, flag_v}), 64'(gflags));
        @(posedge clk); #1;

        // Flush together with valid in IDLE: not taken.
        flush = 1'b1;
        instr = mk_a(5'd0, 3'd7, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", 64'(instr_ready), 64'(1'b0));
        @(posedge clk); #1 flush = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_not_taken", 64'({instr_ready, done}), 64'(2'b10));
        @(posedge clk); #1;

        // Back-to-back with valid held high; first one has rd == rn == rm.
        set_reg(3'd1, 16'h0003);
        run_instr(mk_a(5'd0, 3'd1, 3'd1, 3'd1), 1'b1);
        chk("self_add", 64'(last_wdata), 64'(16'h0006));
        run_instr(mk_a(5'd3, 3'd2, 3'd1, 3'd3), 1'b1);
        run_instr(mk_r(2'b11, 9'h025, 3'd3), 1'b0);

        // Asynchronous reset while in RD_RM.
        instr = mk_a(5'd0, 3'd6, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        gflags = 3'b000;
        @(negedge clk); #2 rst_n = 1'b1;
        #1 chk("ready_after_mid_reset", 64'(instr_ready), 64'(1'b1));
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_reset_no_wb", 64'(regs[6]), 64'(gold[6]));

        // Randomised mix of legal and illegal instructions.
        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [15:0] ins;
            bit          hold;
            sel = int'($urandom_range(0, 9));
            if (sel <= 5)      ins = mk_a(5'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom));
            else if (sel <= 7) ins = mk_r(2'($urandom), 9'($urandom), 3'($urandom));
            else if (sel == 8) ins = mk_a(5'($urandom_range(5, 31)), 3'($urandom), 3'($urandom), 3'($urandom));
            else               ins = {2'($urandom_range(2, 3)), 14'($urandom)};
            hold = (i < 39) && ($urandom_range(0, 3) == 0);
            run_instr(ins, hold);
        end
        instr_valid = 1'b0;

        for (int i = 0; i < 8; i++) chk("final_regs", 64'(regs[i]), 64'(gold[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
